// File: rtl/demux_1_to_3_32_bit_buffered.sv
// demux_1_to_3_32_bit_buffered
// Steers one 32-bit word stream to three independently stalling channels.
// Each channel buffers its words in a DEPTH-entry circular FIFO. Words sent
// to select 2'b11 are consumed and dropped, and a saturating counter tracks them.
//
// Handshake: a transfer happens at a rising edge where valid && ready are both
// high. A source keeps its valid high until the transfer completes, and may
// change payload/select while ready is low. Ready never depends on valid.
// in_ready depends combinationally only on in_sel and the registered FIFO
// state. Channel outputs are driven from registered state only.
module demux_1_to_3_32_bit_buffered #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_0_data,
  output logic [31:0]      out_1_data,
  output logic [31:0]      out_2_data,
  output logic             out_0_valid,
  output logic             out_1_valid,
  output logic             out_2_valid,
  input  logic             out_0_ready,
  input  logic             out_1_ready,
  input  logic             out_2_ready,
  output logic [CNT_W-1:0] drop_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [2:0]  ch_ready;
  logic [2:0]  ch_full;
  logic [2:0]  ch_empty;
  logic [31:0] ch_head [3];

  assign ch_ready = {out_2_ready, out_1_ready, out_0_ready};

  for (genvar k = 0; k < 3; k++) begin : g_ch
    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;

    assign ch_full[k]  = (count == FULL_CNT);
    assign ch_empty[k] = (count == '0);
    // A full FIFO refuses input even if it pops in the same cycle.
    assign push = in_valid && (in_sel == 2'(k)) && !ch_full[k];
    assign pop  = ch_ready[k] && !ch_empty[k];
    assign ch_head[k] = ch_empty[k] ? 32'b0 : mem[rd_ptr];

    // Storage write; contents survive reset since occupancy hides them.
    always_ff @(posedge clk) begin
      if (!rst && push) begin
        mem[wr_ptr] <= in_data;
      end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + (PTR_W + 1)'(1);
          2'b01:   count <= count - (PTR_W + 1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Ready follows the selected channel's not-full flag; drops always accepted.
  always_comb begin
    in_ready = 1'b1;
    case (in_sel)
      2'b00:   in_ready = !ch_full[0];
      2'b01:   in_ready = !ch_full[1];
      2'b10:   in_ready = !ch_full[2];
      default: in_ready = 1'b1;
    endcase
  end

  // Saturating count of words dropped with select 2'b11.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (in_valid && (in_sel == 2'b11) && (drop_count != '1)) begin
      drop_count <= drop_count + CNT_W'(1);
    end
  end

  assign out_0_data  = ch_head[0];
  assign out_1_data  = ch_head[1];
  assign out_2_data  = ch_head[2];
  assign out_0_valid = !ch_empty[0];
  assign out_1_valid = !ch_empty[1];
  assign out_2_valid = !ch_empty[2];

endmodule

// File: tb/tb_demux_1_to_3_32_bit_buffered.sv
// Directed bench for demux_1_to_3_32_bit_buffered: routing, backpressure,
// push/pop wrap, drop counting with saturation, and reset mid-operation.
module tb_demux_1_to_3_32_bit_buffered;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_0_data, out_1_data, out_2_data;
  logic        out_0_valid, out_1_valid, out_2_valid;
  logic        out_0_ready, out_1_ready, out_2_ready;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] w;

  demux_1_to_3_32_bit_buffered #(.DEPTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_0_data(out_0_data), .out_1_data(out_1_data), .out_2_data(out_2_data),
    .out_0_valid(out_0_valid), .out_1_valid(out_1_valid), .out_2_valid(out_2_valid),
    .out_0_ready(out_0_ready), .out_1_ready(out_1_ready), .out_2_ready(out_2_ready),
    .drop_count(drop_count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_v0"}, 32'(out_0_valid), 32'd0);
    check({tag, "_v1"}, 32'(out_1_valid), 32'd0);
    check({tag, "_v2"}, 32'(out_2_valid), 32'd0);
    check({tag, "_d0"}, out_0_data, 32'd0);
    check({tag, "_d1"}, out_1_data, 32'd0);
    check({tag, "_d2"}, out_2_data, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0;
    out_0_ready = 1'b0; out_1_ready = 1'b0; out_2_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    settle();

    // Reset state
    check_idle("rst");
    check("rst_drop", 32'(drop_count), 32'd0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      settle();
      check("rst_ready", 32'(in_ready), 32'd1);
    end

    // Basic routing
    out_0_ready = 1'b1; out_1_ready = 1'b1; out_2_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'hCCCC_CCCC; in_sel = 2'b01;
    settle();
    check("rt_ready", 32'(in_ready), 32'd1);
    tick();
    in_data = 32'hDDDD_DDDD; in_sel = 2'b10;
    settle();
    check("rt_v1", 32'(out_1_valid), 32'd1);
    check("rt_d1", out_1_data, 32'hCCCC_CCCC);
    check("rt_v0", 32'(out_0_valid), 32'd0);
    check("rt_d0", out_0_data, 32'd0);
    tick();
    in_valid = 1'b0;
    settle();
    check("rt_v1_gone", 32'(out_1_valid), 32'd0);
    check("rt_v2", 32'(out_2_valid), 32'd1);
    check("rt_d2", out_2_data, 32'hDDDD_DDDD);
    tick();
    check_idle("rt_end");

    // Fill and backpressure on ch0
    out_0_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'b00; in_data = 32'd1;
    tick();
    in_data = 32'd2;
    settle();
    check("bp_ready_1", 32'(in_ready), 32'd1);
    tick();
    in_data = 32'd3;
    settle();
    check("bp_full", 32'(in_ready), 32'd0);
    in_sel = 2'b01;
    settle();
    check("bp_other", 32'(in_ready), 32'd1);
    in_sel = 2'b00;
    settle();
    check("bp_head1", out_0_data, 32'd1);
    out_0_ready = 1'b1;
    tick();
    check("bp_head2", out_0_data, 32'd2);
    check("bp_ready_after", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    settle();
    check("bp_head3", out_0_data, 32'd3);
    check("bp_v0", 32'(out_0_valid), 32'd1);
    tick();
    check("bp_empty", 32'(out_0_valid), 32'd0);

    // Full-with-pop rule on ch1
    out_1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'b01; in_data = 32'hA1A1_0001;
    tick();
    in_data = 32'hA1A1_0002;
    tick();
    out_1_ready = 1'b1; in_data = 32'hA1A1_0003;
    settle();
    check("fp_ready_low", 32'(in_ready), 32'd0);
    tick();
    check("fp_ready_high", 32'(in_ready), 32'd1);
    check("fp_head2", out_1_data, 32'hA1A1_0002);
    tick();
    in_valid = 1'b0;
    settle();
    check("fp_head3", out_1_data, 32'hA1A1_0003);
    tick();
    check("fp_empty", 32'(out_1_valid), 32'd0);

    // Simultaneous push/pop at occupancy 1 on ch2 for 10 cycles
    out_2_ready = 1'b1;
    in_valid = 1'b1; in_sel = 2'b10;
    w = $urandom; in_data = w; exp_q.push_back(w);
    tick();
    for (int i = 0; i < 10; i++) begin
      w = $urandom; in_data = w; exp_q.push_back(w);
      settle();
      check("pp_ready", 32'(in_ready), 32'd1);
      check("pp_valid", 32'(out_2_valid), 32'd1);
      check("pp_data", out_2_data, exp_q.pop_front());
      tick();
    end
    in_valid = 1'b0;
    settle();
    check("pp_last", out_2_data, exp_q.pop_front());
    tick();
    check("pp_empty", 32'(out_2_valid), 32'd0);

    // Drop path and saturation
    in_valid = 1'b1; in_sel = 2'b11; in_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("dr_ready", 32'(in_ready), 32'd1);
      tick();
    end
    check_idle("dr");
    check("dr_count3", 32'(drop_count), 32'd3);
    for (int i = 0; i < 257; i++) tick();
    check("dr_sat", 32'(drop_count), 32'h0000_00FF);

    // Reset mid-operation
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b1; in_sel = 2'b11;
    for (int i = 0; i < 5; i++) tick();
    out_0_ready = 1'b0; in_sel = 2'b00; in_data = 32'h0000_0A01;
    tick();
    in_data = 32'h0000_0A02;
    tick();
    in_valid = 1'b0;
    settle();
    check("mr_pre_drop", 32'(drop_count), 32'd5);
    check("mr_pre_v0", 32'(out_0_valid), 32'd1);
    check("mr_pre_ready", 32'(in_ready), 32'd0);
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'b01; in_data = 32'h0000_0BAD;
    out_0_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    settle();
    check_idle("mr");
    check("mr_drop", 32'(drop_count), 32'd0);
    tick();
    check_idle("mr_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1_to_3_32_bit_buffered.md
# demux_1_to_3_32_bit_buffered

Inverse of the 3-input word selector: takes one 32-bit word stream and steers each word to one of three output channels by a 2-bit select, buffering each channel in its own small FIFO. Used where a single producer (e.g. a writeback or forwarding source) must feed three independent consumers that can stall independently. Words with the illegal select `2'b11` are consumed and dropped, and are counted.

## Interface
- `DEPTH`, 2: entries per channel FIFO. Power of two, ≥2.
- `CNT_W`, 8: width of the drop counter.

- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input 32: word to dispatch.
- `in_sel` input 2: destination. `00` → ch0, `01` → ch1, `10` → ch2, `11` → drop.
- `in_valid` input 1: `in_data`/`in_sel` valid this cycle.
- `in_ready` output 1: block accepts the word this cycle.
- `out_0_data`, `out_1_data`, `out_2_data` output 32 each: head word of the channel FIFO. `32'b0` when the FIFO is empty.
- `out_0_valid`, `out_1_valid`, `out_2_valid` output 1 each: channel FIFO non-empty.
- `out_0_ready`, `out_1_ready`, `out_2_ready` input 1 each: consumer takes the head word.
- `drop_count` output `CNT_W`: number of words dropped with sel `11`. Saturates at all-ones.

## Operation
- Transfer in: `in_valid && in_ready` at a rising edge.
- `in_ready` is combinational from `in_sel` and FIFO state:
  - `1` if `in_sel == 11`.
  - Otherwise it is the not-full flag of the selected FIFO.
  - Ready does not depend on `in_valid`.
- Accepted word with sel `00`/`01`/`10`: written to the tail of that channel's FIFO. The other FIFOs are untouched.
- Accepted word with sel `11`: discarded. `drop_count` increments by 1, except when already all-ones.
- Transfer out on channel k: `out_k_valid && out_k_ready` at a rising edge. This pops the head. `out_k_ready` while `out_k_valid` is low has no effect.
- Each FIFO has:
  - A circular buffer of `DEPTH` entries.
  - Read and write pointers of log2(DEPTH) bits that wrap modulo `DEPTH`.
  - An occupancy counter of log2(DEPTH)+1 bits.
  - Full when occupancy is `DEPTH`; empty when occupancy is 0.
- Full FIFO: `in_ready` is low for that select, even if the same channel pops in the same cycle. There is no pass-through-on-pop.
- Non-full, non-empty FIFO with push and pop in the same cycle: occupancy is unchanged, both pointers advance, and data order is preserved.
- Channels are fully independent. One stalled channel blocks the input only while `in_sel` points at it.
- Changing `in_sel` while `in_valid` is high and `in_ready` is low is legal. Only the value sampled at the accepting edge matters.
- Ordering: words to the same channel leave in acceptance order.

## Timing
- Reset (sync, `rst` high at a rising edge):
  - All occupancies, pointers and `drop_count` go to 0.
  - All `out_k_valid` go to 0 and all `out_k_data` read `32'b0`.
  - `in_ready` is then `1` for every `in_sel`.
  - FIFO storage contents need not be cleared.
- Reset mid-operation: buffered words are lost. Any transfer presented on the reset edge, in or out, is ignored.
- Latency:
  - A word accepted at edge N is visible on `out_k_data` with `out_k_valid = 1` after edge N, i.e. one cycle. It can be popped at edge N+1 at the earliest.
  - No combinational path from `in_data` to `out_k_data`.
- `out_k_data` and `out_k_valid` are functions of registered state only.
- `in_ready` has a combinational path from `in_sel` only.
- Throughput: one word per cycle in, and one per cycle per channel out, provided consumers keep up.
- `drop_count` updates on the accepting edge and is visible after it.

## Test plan
- **Basic routing:** after reset, send `32'hCCCC_CCCC` sel `01`, then `32'hDDDD_DDDD` sel `10`, with all out_ready high → each word appears exactly one cycle after acceptance on ch1 and ch2 respectively. ch0 stays invalid with data `32'b0`.
- **Fill and backpressure:** hold `out_0_ready = 0` and push `1`, `2`, `3` sel `00`.
  - After 2 accepts, `in_ready = 0` while sel is `00`; switching sel to `01` gives `in_ready = 1`.
  - Releasing `out_0_ready` pops `1` then `2`, and only then is `3` accepted.
- **Simultaneous push/pop at occupancy 1 on ch2, for 10 cycles:** occupancy stays 1 and the output sequence equals the input sequence delayed by one word. This exercises pointer wrap-around.
- **Drop path:** send 3 words with sel `11` → `in_ready = 1` each cycle, no channel goes valid, `drop_count = 3`. Force 260 drops → `drop_count = 8'hFF`.
- **Reset mid-operation:** with ch0 holding 2 words and `drop_count = 5`, assert `rst` for one edge → all valids are 0, all data read `32'b0`, `drop_count = 0`, and the word presented on the reset edge is not stored.
- **Full-with-pop rule:** ch1 full and `out_1_ready = 1`, with a sel `01` word presented → `in_ready = 0` that cycle. The word is accepted the next cycle.
